// File: rtl/itype_issue_scheduler_pkg.sv
// Shared definitions for the I-type issue scheduler: opcodes, default widths
// and the issue-entry layout carried through the issue FIFO.
package itype_issue_scheduler_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_RF_WIDTH    = 5;
  localparam int unsigned DEF_FUNC3_WIDTH = 3;
  localparam int unsigned DEF_TAG_WIDTH   = 7;
  localparam int unsigned DEF_EXEC_WIDTH  = 4;
  localparam int unsigned DEF_QUEUE_DEPTH = 4;

  localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;

  typedef struct packed {
    logic                       load;
    logic [DEF_RF_WIDTH-1:0]    rs1;
    logic [DEF_RF_WIDTH-1:0]    rd;
    logic [DEF_FUNC3_WIDTH-1:0] func3;
    logic [DEF_DATA_WIDTH-1:0]  imm;
    logic [DEF_TAG_WIDTH-1:0]   tag;
  } issue_entry_t;

endpackage

// File: rtl/itype_issue_scheduler_rr.sv
// Round-robin picker: first free ALU at or after rr_ptr, wrapping modulo
// EXEC_WIDTH. Purely combinational.
module issue_rr_picker #(
  parameter int unsigned EXEC_WIDTH = 4,
  parameter int unsigned RR_W       = 2
) (
  input  logic [EXEC_WIDTH-1:0] free,
  input  logic [RR_W-1:0]       rr_ptr,
  output logic [EXEC_WIDTH-1:0] grant,
  output logic [RR_W-1:0]       grant_idx,
  output logic                  any_grant
);

  logic [RR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < EXEC_WIDTH; i++) begin
      idx = RR_W'((32'(rr_ptr) + i) % EXEC_WIDTH);
      if (!any_grant && free[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/itype_issue_scheduler.sv
// In-order issue controller for decoded I-type ops: FIFO buffering, RAW/WAW
// scoreboard blocking, round-robin ALU dispatch and a single load port.
module itype_issue_scheduler
  import itype_issue_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned RF_WIDTH    = DEF_RF_WIDTH,
  parameter int unsigned FUNC3_WIDTH = DEF_FUNC3_WIDTH,
  parameter int unsigned TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int unsigned EXEC_WIDTH  = DEF_EXEC_WIDTH,
  parameter int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_load,
  input  logic [RF_WIDTH-1:0]    in_rs1,
  input  logic [RF_WIDTH-1:0]    in_rd,
  input  logic [FUNC3_WIDTH-1:0] in_func3,
  input  logic [DATA_WIDTH-1:0]  in_imm,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  input  logic [EXEC_WIDTH-1:0]  alu_busy,
  output logic [EXEC_WIDTH-1:0]  alu_issue,
  input  logic                   ld_ready,
  output logic                   ld_issue,
  output logic [RF_WIDTH-1:0]    iss_rs1,
  output logic [RF_WIDTH-1:0]    iss_rd,
  output logic [FUNC3_WIDTH-1:0] iss_func3,
  output logic [DATA_WIDTH-1:0]  iss_imm,
  output logic [TAG_WIDTH-1:0]   iss_tag,
  input  logic                   wb_valid,
  input  logic [RF_WIDTH-1:0]    wb_rd
);

  localparam int unsigned QA_W  = $clog2(QUEUE_DEPTH);
  localparam int unsigned RR_W  = (EXEC_WIDTH > 1) ? $clog2(EXEC_WIDTH) : 1;
  localparam int unsigned NREGS = 1 << RF_WIDTH;

  // Same field order as issue_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic                   load;
    logic [RF_WIDTH-1:0]    rs1;
    logic [RF_WIDTH-1:0]    rd;
    logic [FUNC3_WIDTH-1:0] func3;
    logic [DATA_WIDTH-1:0]  imm;
    logic [TAG_WIDTH-1:0]   tag;
  } entry_t;

  entry_t          mem [QUEUE_DEPTH];
  entry_t          head;
  entry_t          in_entry;
  logic [QA_W-1:0] wr_ptr;
  logic [QA_W-1:0] rd_ptr;
  logic [QA_W:0]   count;
  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_next;
  logic [RR_W-1:0] rr_ptr;
  logic [RR_W-1:0] rr_next;
  logic [RR_W-1:0] grant_idx;
  logic [EXEC_WIDTH-1:0] grant;
  logic any_grant;
  logic full, empty, hazard, alu_go, ld_go, push, pop;

  assign full     = (count == (QA_W + 1)'(QUEUE_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  assign in_entry = '{load: in_load, rs1: in_rs1, rd: in_rd, func3: in_func3,
                      imm: in_imm, tag: in_tag};
  assign head     = mem[rd_ptr];

  // Hazard looks only at registered scoreboard state; same-cycle writeback
  // releases the op one cycle later.
  assign hazard = sb[head.rs1] | sb[head.rd];

  issue_rr_picker #(
    .EXEC_WIDTH(EXEC_WIDTH),
    .RR_W      (RR_W)
  ) u_picker (
    .free     (~alu_busy),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any_grant(any_grant)
  );

  assign alu_go    = !empty && !head.load && !hazard && any_grant;
  assign ld_go     = !empty &&  head.load && !hazard && ld_ready;
  assign pop       = alu_go || ld_go;
  assign alu_issue = alu_go ? grant : '0;
  assign ld_issue  = ld_go;
  assign rr_next   = RR_W'((32'(grant_idx) + 1) % EXEC_WIDTH);

  assign iss_rs1   = empty ? '0 : head.rs1;
  assign iss_rd    = empty ? '0 : head.rd;
  assign iss_func3 = empty ? '0 : head.func3;
  assign iss_imm   = empty ? '0 : head.imm;
  assign iss_tag   = empty ? '0 : head.tag;

  // Clear before set so an issue and writeback to the same register leave it set.
  always_comb begin
    sb_next = sb;
    if (wb_valid) sb_next[wb_rd] = 1'b0;
    if (pop) sb_next[head.rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sb     <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      sb <= sb_next;
      if (alu_go) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_itype_issue_scheduler.sv
// Scoreboard bench for itype_issue_scheduler: a queue-based reference model
// predicts each issue; a monitor checks every strobe the DUT raises.
module tb_itype_issue_scheduler;
  import itype_issue_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rd;
  logic [2:0]  in_func3;
  logic [31:0] in_imm;
  logic [6:0]  in_tag;
  logic [3:0]  alu_busy;
  logic [3:0]  alu_issue;
  logic        ld_ready;
  logic        ld_issue;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rd;
  logic [2:0]  iss_func3;
  logic [31:0] iss_imm;
  logic [6:0]  iss_tag;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  itype_issue_scheduler #(
    .DATA_WIDTH (32),
    .RF_WIDTH   (5),
    .FUNC3_WIDTH(3),
    .TAG_WIDTH  (7),
    .EXEC_WIDTH (4),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_load  (in_load),
    .in_rs1   (in_rs1),
    .in_rd    (in_rd),
    .in_func3 (in_func3),
    .in_imm   (in_imm),
    .in_tag   (in_tag),
    .alu_busy (alu_busy),
    .alu_issue(alu_issue),
    .ld_ready (ld_ready),
    .ld_issue (ld_issue),
    .iss_rs1  (iss_rs1),
    .iss_rd   (iss_rd),
    .iss_func3(iss_func3),
    .iss_imm  (iss_imm),
    .iss_tag  (iss_tag),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [56:0] v;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int n_exp = 0;
  int n_obs = 0;
  int tag_ctr = 1;

  // Reference model: queue of pending ops, one bit per register, rr pointer.
  issue_entry_t mfifo[$];
  bit [31:0]    msb = '0;
  int           mrr = 0;

  always @(negedge clk) begin
    issue_entry_t h;
    issue_entry_t n;
    exp_t         e;
    bit           alu_go;
    bit           ld_go;
    logic [3:0]   oh;
    int           sz;
    int           u;
    sz = mfifo.size();
    alu_go = 0;
    ld_go = 0;
    oh = '0;
    h = '0;
    checks++;
    if (in_ready !== (sz < 4)) begin
      failures++;
      $display("FAIL in_ready cyc=%0d actual=%b required=%b", cyc, in_ready, sz < 4);
    end
    if (sz > 0) begin
      h = mfifo[0];
      if (!(msb[h.rs1] || msb[h.rd])) begin
        if (h.load) begin
          ld_go = ld_ready;
        end else begin
          for (int k = 0; k < 4; k++) begin
            u = (mrr + k) % 4;
            if (!alu_go && !alu_busy[u]) begin
              alu_go = 1;
              oh[u] = 1'b1;
              mrr = (u + 1) % 4;
            end
          end
        end
      end
    end else begin
      checks++;
      if ({iss_rs1, iss_rd, iss_func3, iss_imm, iss_tag} !== '0) begin
        failures++;
        $display("FAIL empty_payload cyc=%0d actual=%h required=0", cyc,
                 {iss_rs1, iss_rd, iss_func3, iss_imm, iss_tag});
      end
    end
    if (alu_go || ld_go) begin
      e.cyc = cyc;
      e.v = {oh, ld_go, h.rs1, h.rd, h.func3, h.imm, h.tag};
      exp_q.push_back(e);
      n_exp++;
      void'(mfifo.pop_front());
    end
    if (wb_valid) msb[wb_rd] = 1'b0;
    if (alu_go || ld_go) msb[h.rd] = 1'b1;
    msb[0] = 1'b0;
    if (in_valid && sz < 4) begin
      n.load = in_load;
      n.rs1 = in_rs1;
      n.rd = in_rd;
      n.func3 = in_func3;
      n.imm = in_imm;
      n.tag = in_tag;
      mfifo.push_back(n);
    end
    if (rst) begin
      mfifo.delete();
      msb = '0;
      mrr = 0;
    end
  end

  // Monitor: compares every strobe against the oldest prediction.
  always @(negedge clk) begin
    exp_t        e;
    logic [56:0] act;
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_issue cyc=%0d actual=none required=%h@%0d", cyc, e.v, e.cyc);
    end
    if (alu_issue != '0 || ld_issue) begin
      n_obs++;
      checks++;
      act = {alu_issue, ld_issue, iss_rs1, iss_rd, iss_func3, iss_imm, iss_tag};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue cyc=%0d actual=%h required=none", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== act) begin
          failures++;
          $display("FAIL issue cyc=%0d actual=%h required=%h@%0d", cyc, act, e.v, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input bit ld, input int rs1, input int rd, input int f3);
    in_valid = 1'b1;
    in_load  = ld;
    in_rs1   = 5'(rs1);
    in_rd    = 5'(rd);
    in_func3 = 3'(f3);
    in_imm   = $urandom;
    in_tag   = 7'(tag_ctr);
    tag_ctr++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wb(input int rd);
    wb_valid = 1'b1;
    wb_rd = 5'(rd);
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_load = 1'b0;
    in_rs1 = '0;
    in_rd = '0;
    in_func3 = '0;
    in_imm = '0;
    in_tag = '0;
    alu_busy = '0;
    ld_ready = 1'b1;
    wb_valid = 1'b0;
    wb_rd = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // ADDI rd=5 then dependent rd=6 rs1=5, released only after wb of x5
    push_op(0, 0, 5, 0);
    push_op(0, 5, 6, 1);
    repeat (3) tick();
    wb(5);
    repeat (2) tick();
    wb(6);

    // Round robin with ALU1 busy, starting from rr_ptr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_busy = 4'b0010;
    for (int i = 0; i < 4; i++) push_op(0, 0, 10 + i, i);
    repeat (2) tick();
    alu_busy = 4'b0000;
    push_op(0, 0, 0, 7);
    tick();
    for (int i = 0; i < 4; i++) wb(10 + i);

    // Full FIFO of loads with the load unit stalled; fifth push is refused
    ld_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(1, 0, 20 + i, 2);
    repeat (2) tick();
    ld_ready = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < 5; i++) wb(20 + i);

    // x0 destination never blocks; issue rd=7 alongside wb x7 keeps x7 busy
    push_op(0, 0, 0, 3);
    push_op(0, 0, 3, 4);
    push_op(0, 0, 7, 5);
    wb_valid = 1'b1;
    wb_rd = 5'd7;
    push_op(0, 7, 8, 6);
    wb_valid = 1'b0;
    repeat (3) tick();
    wb(7);
    tick();
    wb(8);
    wb(3);

    // Reset with three queued ops and x9 pending
    push_op(0, 0, 9, 1);
    tick();
    alu_busy = 4'b1111;
    ld_ready = 1'b0;
    push_op(0, 0, 1, 0);
    push_op(1, 0, 2, 0);
    push_op(0, 0, 4, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_busy = 4'b0000;
    ld_ready = 1'b1;
    tick();
    push_op(0, 9, 9, 2);
    repeat (2) tick();
    wb(9);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom % 2);
      in_load  = ($urandom % 3) == 0;
      in_rs1   = 5'($urandom % 8);
      in_rd    = 5'($urandom % 8);
      in_func3 = 3'($urandom);
      in_imm   = $urandom;
      in_tag   = 7'(tag_ctr);
      tag_ctr++;
      alu_busy = 4'($urandom);
      ld_ready = ($urandom % 4) != 0;
      wb_valid = ($urandom % 3) == 0;
      wb_rd    = 5'($urandom % 8);
      rst      = ($urandom % 200) == 0;
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    alu_busy = '0;
    ld_ready = 1'b1;
    for (int i = 0; i < 64; i++) wb(i % 8);
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0 || n_exp != n_obs) begin
      failures++;
      $display("FAIL drain actual=obs%0d/left%0d required=obs%0d/left0", n_obs, exp_q.size(), n_exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
